modulo_controlador_temporizador: RTL and testbench
==================================================

MODULO_CONTROLADOR_TEMPORIZADOR -- requirements
Module: modulo_controlador_temporizador

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, prescaler counter width (must hold largest divisor - 1).
REQ-002 SHALL have parameter CNT_W, default 8, width of period and remaining count.
REQ-003 SHALL have port clock  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port clear  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request a timing run, sampled only in IDLE.
REQ-006 SHALL have port pause  input  1  level; hold timing while high.
REQ-007 SHALL have port cancel  input  1  abort the run, highest priority.
REQ-008 SHALL have port sel_div  input  2  tick divisor select: 00=16, 01=256, 10=4096, 11=65536 clocks.
REQ-009 SHALL have port period  input  CNT_W  number of ticks per run, sampled with start.
REQ-010 SHALL have port busy  output  1  high in CONTANDO or PAUSADO.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port tick  output  1  one-cycle pulse per elapsed prescaler period.
REQ-013 SHALL have port remaining  output  CNT_W  ticks left in current run.
REQ-014 SHALL have port estado  output  2  current state encoding.

Function
REQ-015 SHALL implement states IDLE=00, CONTANDO=01, PAUSADO=10, FIM=11; all logic synchronous to clock except reset.
REQ-016 IDLE, start=1, period!=0: SHALL latch period into remaining, latch sel_div, zero prescaler, go CONTANDO.
REQ-017 IDLE, start=1, period=0: SHALL go FIM directly, remaining stays 0.
REQ-018 start outside IDLE SHALL be ignored; period/sel_div changes outside IDLE SHALL have no effect.
REQ-019 In CONTANDO the prescaler SHALL increment every cycle; tick SHALL be high for the cycle where prescaler = divisor-1, prescaler wrapping to 0 on that edge.
REQ-020 Edge with tick=1 in CONTANDO SHALL decrement remaining; if remaining was 1, SHALL go FIM with remaining=0.
REQ-021 Priority per edge: cancel > tick/completion > pause; a tick coincident with pause assertion SHALL be counted.
REQ-022 CONTANDO with pause=1 SHALL go PAUSADO; PAUSADO SHALL freeze prescaler and remaining, tick=0.
REQ-023 PAUSADO with pause=0 SHALL return to CONTANDO, prescaler resuming from frozen value.
REQ-024 cancel=1 in CONTANDO or PAUSADO SHALL go IDLE, clear remaining and prescaler, no done pulse.
REQ-025 done SHALL be high exactly the one cycle the FSM is in FIM; FIM SHALL always go IDLE next edge.
REQ-026 Latency: for period N, divisor D, without pause, done SHALL be high in the cycle after the (N*D)-th rising edge following the edge that sampled start.
REQ-027 remaining arithmetic SHALL never wrap below 0.

Reset
REQ-028 clear=0 SHALL immediately force estado=IDLE, remaining=0, prescaler=0, busy=0, done=0, tick=0, regardless of operation in progress.
REQ-029 After clear returns high, the block SHALL accept start on the first rising edge.

Structure
REQ-030 State encodings and the four divisor constants SHALL reside in shared package modulo_temporizador_pkg.
REQ-031 The prescaler SHALL be sub-module modulo_prescaler (synchronous counter with enable, clear-to-zero and one-cycle tick output); no derived or ripple clocks.

Verification
REQ-032 sel_div=00, period=3, start pulse -> tick at edges 16,32,48; remaining 3->2->1->0; done one cycle after edge 48; busy low afterwards.
REQ-033 sel_div=00, period=2, pause high edges 10..29 -> done delayed exactly 20 cycles (after edge 52); remaining frozen at 2 during pause.
REQ-034 sel_div=01, period=5, cancel at edge 300 -> IDLE next cycle, remaining=0, done never asserted.
REQ-035 period=0 with start -> done high in the cycle after the start edge, busy never high.
REQ-036 clear low mid-run (sel=00, period=4, edge 20) -> all outputs zero immediately; start after release with period=1 -> done after 16 edges.
REQ-037 start re-asserted with period=9 during run of period=2 -> ignored; done after 32 edges (sel=00).

Source files
------------

// File: rtl/modulo_temporizador_pkg.sv
// Shared definitions for the timer controller: FSM state encoding, the four
// prescaler divisors and a helper that maps the divisor select to a divisor.
package modulo_temporizador_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    FIM      = 2'b11
  } estado_t;

  localparam int unsigned DIV_16    = 16;
  localparam int unsigned DIV_256   = 256;
  localparam int unsigned DIV_4096  = 4096;
  localparam int unsigned DIV_65536 = 65536;

  // Number of clock cycles per tick for a given sel_div code.
  function automatic int unsigned divisor_of(input logic [1:0] sel);
    int unsigned result;
    result = DIV_16;
    unique case (sel)
      2'b00: result = DIV_16;
      2'b01: result = DIV_256;
      2'b10: result = DIV_4096;
      2'b11: result = DIV_65536;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/modulo_prescaler.sv
// Prescaler for the timer controller: a synchronous counter that advances
// while enabled, wraps to zero after reaching 'limit' and pulses 'tick' for
// the single cycle the count sits at the limit.
//
// Ports:
//   clock  - system clock, rising edge
//   clear  - asynchronous active-low reset
//   enable - count this cycle (counter frozen when low)
//   zero   - synchronous clear to zero, overrides enable
//   limit  - divisor minus one
//   tick   - high while enabled and count == limit
module modulo_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               enable,
  input  logic               zero,
  input  logic [PRESC_W-1:0] limit,
  output logic               tick
);

  logic [PRESC_W-1:0] count;
  logic               at_limit;

  assign at_limit = (count == limit);
  assign tick     = enable & at_limit;

  // Counter register; the wrap happens on the same edge that consumes the tick.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (enable) begin
      count <= at_limit ? '0 : count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/modulo_controlador_temporizador.sv
// Timer controller: counts 'period' ticks of a selectable prescaler, with
// pause/resume, cancel and a one-cycle completion pulse.
//
// Ports:
//   clock     - system clock, rising edge
//   clear     - asynchronous active-low reset
//   start     - begin a run (only honoured in IDLE)
//   pause     - level, holds the run while high
//   cancel    - abort a run in progress, highest priority
//   sel_div   - tick divisor select (16/256/4096/65536 clocks)
//   period    - ticks per run, captured with start
//   busy      - run in progress (CONTANDO or PAUSADO)
//   done      - one-cycle completion pulse (state FIM)
//   tick      - one-cycle pulse per elapsed prescaler period
//   remaining - ticks left in the current run
//   estado    - current state encoding
module modulo_controlador_temporizador
  import modulo_temporizador_pkg::*;
#(
  parameter int PRESC_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  input  logic [1:0]       sel_div,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       estado
);

  estado_t            state, state_next;
  logic [CNT_W-1:0]   rem_q, rem_next;
  logic [1:0]         sel_q, sel_next;
  logic [PRESC_W-1:0] limit;
  logic               presc_tick;
  logic               presc_enable;
  logic               presc_zero;

  // The divisor is taken from the select captured at start, so changes on
  // sel_div during a run cannot disturb it.
  assign limit        = PRESC_W'(divisor_of(sel_q) - 32'd1);
  assign presc_enable = (state == CONTANDO);
  // Hold the prescaler at zero outside a run and on cancel; PAUSADO keeps it.
  assign presc_zero   = (state == IDLE) || (state == FIM) || (busy && cancel);

  modulo_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clock  (clock),
    .clear  (clear),
    .enable (presc_enable),
    .zero   (presc_zero),
    .limit  (limit),
    .tick   (presc_tick)
  );

  // State, remaining count and captured divisor select.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      rem_q <= '0;
      sel_q <= '0;
    end else begin
      state <= state_next;
      rem_q <= rem_next;
      sel_q <= sel_next;
    end
  end

  // Next-state logic. Within CONTANDO the order is cancel, then tick (and
  // completion), then pause, so a tick landing with pause is still counted.
  always_comb begin
    state_next = state;
    rem_next   = rem_q;
    sel_next   = sel_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (period != '0) begin
            rem_next   = period;
            sel_next   = sel_div;
            state_next = CONTANDO;
          end else begin
            state_next = FIM;
          end
        end
      end
      CONTANDO: begin
        if (cancel) begin
          rem_next   = '0;
          state_next = IDLE;
        end else if (presc_tick) begin
          if (rem_q <= CNT_W'(1)) begin
            rem_next   = '0;
            state_next = FIM;
          end else begin
            rem_next = rem_q - CNT_W'(1);
            if (pause) begin
              state_next = PAUSADO;
            end
          end
        end else if (pause) begin
          state_next = PAUSADO;
        end
      end
      PAUSADO: begin
        if (cancel) begin
          rem_next   = '0;
          state_next = IDLE;
        end else if (!pause) begin
          state_next = CONTANDO;
        end
      end
      FIM: begin
        rem_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state == CONTANDO) || (state == PAUSADO);
  assign done      = (state == FIM);
  assign tick      = presc_tick;
  assign remaining = rem_q;
  assign estado    = state;

endmodule

// File: tb/tb_modulo_controlador_temporizador.sv
// Self-checking bench for modulo_controlador_temporizador: directed scenarios
// for the documented timing cases plus randomized runs, all compared every
// cycle against a behavioural model of the timer.
module tb_modulo_controlador_temporizador;

  localparam int PRESC_W = 16;
  localparam int CNT_W   = 8;

  logic             clock = 1'b0;
  logic             clear;
  logic             start;
  logic             pause;
  logic             cancel;
  logic [1:0]       sel_div;
  logic [CNT_W-1:0] period;
  logic             busy;
  logic             done;
  logic             tick;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       estado;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a run is "running" with some ticks left and a
  // position inside the current divisor period; "fim" is the completion cycle.
  bit m_running;
  bit m_paused;
  bit m_fim;
  int m_left;
  int m_phase;
  int m_div;

  modulo_controlador_temporizador #(
    .PRESC_W (PRESC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .pause     (pause),
    .cancel    (cancel),
    .sel_div   (sel_div),
    .period    (period),
    .busy      (busy),
    .done      (done),
    .tick      (tick),
    .remaining (remaining),
    .estado    (estado)
  );

  always #5 clock = ~clock;

  function automatic int divFor(input logic [1:0] sel);
    return 16 << (4 * int'(sel));
  endfunction

  task automatic modelReset();
    m_running = 1'b0;
    m_paused  = 1'b0;
    m_fim     = 1'b0;
    m_left    = 0;
    m_phase   = 0;
    m_div     = 16;
  endtask

  // One rising edge of the reference timer, using the inputs present at it.
  task automatic modelStep();
    if (m_fim) begin
      m_fim = 1'b0;
    end else if (!m_running) begin
      if (start) begin
        if (period == '0) begin
          m_fim = 1'b1;
        end else begin
          m_running = 1'b1;
          m_paused  = 1'b0;
          m_left    = int'(period);
          m_div     = divFor(sel_div);
          m_phase   = 0;
        end
      end
    end else if (cancel) begin
      m_running = 1'b0;
      m_paused  = 1'b0;
      m_left    = 0;
      m_phase   = 0;
    end else if (m_paused) begin
      if (!pause) m_paused = 1'b0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == m_div) begin
        m_phase = 0;
        m_left  = m_left - 1;
        if (m_left == 0) begin
          m_running = 1'b0;
          m_fim     = 1'b1;
        end
      end
      if (m_running && pause) m_paused = 1'b1;
    end
  endtask

  function automatic int expEstado();
    if (m_fim)     return 3;
    if (!m_running) return 0;
    if (m_paused)  return 2;
    return 1;
  endfunction

  function automatic bit expTick();
    return m_running && !m_paused && (m_phase == m_div - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll(input string where);
    checkOutput({where, ".busy"},      32'(busy),      32'(m_running));
    checkOutput({where, ".done"},      32'(done),      32'(m_fim));
    checkOutput({where, ".tick"},      32'(tick),      32'(expTick()));
    checkOutput({where, ".remaining"}, 32'(remaining), 32'(m_left));
    checkOutput({where, ".estado"},    32'(estado),    32'(expEstado()));
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic [1:0] sd, input logic [CNT_W-1:0] per);
    start   = s;
    pause   = p;
    cancel  = c;
    sel_div = sd;
    period  = per;
  endtask

  // Called at a falling edge: advance one rising edge, then check at the next fall.
  task automatic cycle();
    @(posedge clock);
    modelStep();
    @(negedge clock);
    compareAll("cyc");
  endtask

  // Asynchronous clear mid-cycle: outputs must drop before any clock edge.
  task automatic doClear();
    clear = 1'b0;
    #1;
    modelReset();
    compareAll("clr");
    checkOutput("clr.busy_now", 32'(busy), 32'd0);
    checkOutput("clr.estado_now", 32'(estado), 32'd0);
    @(negedge clock);
    compareAll("clr_hold");
    clear = 1'b1;
  endtask

  // Start a run at edge 0, then drive pause/cancel/restart by edge number.
  task automatic runScenario(input logic [1:0] sel, input int per, input int maxc,
                             input int pauseLo, input int pauseHi,
                             input int cancelAt, input int restartAt,
                             output int doneEdge, output int tickCount);
    applyStimulus(1'b1, 1'b0, 1'b0, sel, CNT_W'(per));
    cycle();
    doneEdge  = -1;
    tickCount = 0;
    for (int k = 1; k <= maxc; k++) begin
      applyStimulus(k == restartAt, (k >= pauseLo) && (k <= pauseHi), k == cancelAt,
                    2'($urandom), CNT_W'(9));
      cycle();
      if (tick) tickCount++;
      if (pauseLo > 0 && k == (pauseLo + pauseHi) / 2)
        checkOutput("pause.frozen", 32'(remaining), 32'(per));
      if (k == cancelAt) begin
        checkOutput("cancel.estado", 32'(estado), 32'd0);
        checkOutput("cancel.remaining", 32'(remaining), 32'd0);
      end
      if (done) begin
        doneEdge = k;
        break;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0);
    cycle();
    checkOutput("after.busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int  doneEdge;
    int  tickCount;
    int  guard;
    int  per;
    logic [1:0] sel;
    logic pz;

    clear = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0);
    modelReset();
    @(negedge clock);
    compareAll("reset");
    checkOutput("reset.estado", 32'(estado), 32'd0);
    clear = 1'b1;
    cycle();
    cycle();

    // Three ticks of 16 clocks, done after edge 48.
    runScenario(2'b00, 3, 100, 0, -1, -1, -1, doneEdge, tickCount);
    checkOutput("basic.done_edge", 32'(doneEdge), 32'd48);
    checkOutput("basic.ticks", 32'(tickCount), 32'd3);

    // Pause over edges 10..29 delays completion by 20 cycles.
    runScenario(2'b00, 2, 200, 10, 29, -1, -1, doneEdge, tickCount);
    checkOutput("pause.done_edge", 32'(doneEdge), 32'd52);

    // Cancel at edge 300 of a 5x256 run: no completion at all.
    runScenario(2'b01, 5, 400, 0, -1, 300, -1, doneEdge, tickCount);
    checkOutput("cancel.no_done", 32'(doneEdge), 32'hFFFF_FFFF);

    // Zero period goes straight to completion.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, '0);
    cycle();
    checkOutput("zero.done", 32'(done), 32'd1);
    checkOutput("zero.busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0);
    cycle();
    checkOutput("zero.after", 32'(done), 32'd0);

    // Clear mid-run, then a one-tick run accepted on the first edge after release.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, CNT_W'(4));
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, CNT_W'(4));
    repeat (19) cycle();
    doClear();
    runScenario(2'b00, 1, 100, 0, -1, -1, -1, doneEdge, tickCount);
    checkOutput("clear.restart_edge", 32'(doneEdge), 32'd16);

    // A second start during a run is ignored.
    runScenario(2'b00, 2, 100, 0, -1, -1, 5, doneEdge, tickCount);
    checkOutput("restart.ignored", 32'(doneEdge), 32'd32);

    // One run on the 4096 divisor.
    runScenario(2'b10, 1, 5000, 0, -1, -1, -1, doneEdge, tickCount);
    checkOutput("div4096.done_edge", 32'(doneEdge), 32'd4096);

    // Randomized runs with bursty pause, rare cancel/clear and input noise.
    pz = 1'b0;
    for (int r = 0; r < 150; r++) begin
      repeat ($urandom_range(0, 3)) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'($urandom), CNT_W'($urandom));
        cycle();
      end
      sel = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00;
      per = $urandom_range(0, 6);
      applyStimulus(1'b1, $urandom_range(0, 3) == 0, 1'b0, sel, CNT_W'(per));
      cycle();
      guard = 0;
      while ((m_running || m_fim) && guard < 3000) begin
        if ($urandom_range(0, 15) == 0) pz = ~pz;
        applyStimulus($urandom_range(0, 7) == 0, pz, $urandom_range(0, 199) == 0,
                      2'($urandom), CNT_W'($urandom));
        if ($urandom_range(0, 499) == 0) doClear();
        else cycle();
        guard++;
      end
      if (guard >= 3000) checkOutput("rand.timeout", 32'(guard), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
